// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: address widths, broadcast address,
// header sizes, filter FSM states and a saturating length increment.
package eth_pkg;

  localparam int ETH_ADDR_W        = 48;
  localparam int ETH_HDR_DST_BYTES = 6;

  localparam logic [ETH_ADDR_W-1:0] ETH_BCAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PASS,
    DROP,
    FLUSH
  } rx_filter_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_shift_buf.sv
// Byte delay line holding the destination MAC while the filter decides.
// Push/pop in the same cycle keeps the fill level constant.
module eth_rx_shift_buf
  import eth_pkg::*;
#(
  parameter int DEPTH = ETH_HDR_DST_BYTES,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [7:0]                 din_i,
  output logic [7:0]                 dout_o,
  output logic [DEPTH-2:0][7:0]      hdr_o,
  output logic [CW-1:0]              cnt_o
);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_d = cnt_q - 1'b1;
    end
    if (push_i && cnt_d < CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_d) mem_d[i] = din_i;
      end
      cnt_d = cnt_d + 1'b1;
    end
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o = mem_q[0];
  assign hdr_o  = mem_q[DEPTH-2:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/eth_rx_addr_filter.sv
// RX destination-MAC filter with runt/oversize flagging.
// Optional frame counters enabled by ETH_RX_FILTER_STATS_EN.
module eth_rx_addr_filter
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic [ETH_ADDR_W-1:0] local_mac,
  input  logic                  promisc,
  input  logic                  bcast_en,
  input  logic                  mcast_en,
  output logic                  drop_frame,
  output logic                  error_runt,
  output logic                  error_oversize,
  output logic [31:0]           stat_ok,
  output logic [31:0]           stat_drop,
  output logic [31:0]           stat_err
);

  localparam int DB = ETH_HDR_DST_BYTES;
  localparam int CW = $clog2(DB + 1);

  rx_filter_state_t state_q, state_d;

  logic [15:0] len_q, len_d, len_inc;
  logic        usr_q, usr_d;
  logic        runt_q, runt_d, runt_nx;
  logic        over_q, over_d, over_nx;
  logic        ovl_q, ovl_d, ovl_nx;
  logic [7:0]  m_d_q, m_d_d;
  logic        m_v_q, m_v_d;
  logic        m_l_q, m_l_d;
  logic        m_u_q, m_u_d;
  logic        drop_q, drop_d;
  logic        er_q, er_d;
  logic        eo_q, eo_d;

  logic                 push, pop, clr;
  logic                 beat, last, match;
  logic [7:0]           dout;
  logic [DB-2:0][7:0]   hdr;
  logic [CW-1:0]        cnt;
  logic [ETH_ADDR_W-1:0] dst;

  eth_rx_shift_buf #(.DEPTH(DB)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (s_axis_tdata),
    .dout_o (dout),
    .hdr_o  (hdr),
    .cnt_o  (cnt)
  );

  // Byte 5 is still on the input when the decision is made.
  assign dst = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], s_axis_tdata};

  assign match = promisc
               | (dst == local_mac)
               | (bcast_en & (dst == ETH_BCAST_ADDR))
               | (mcast_en & dst[40]);

  assign beat    = s_axis_tvalid;
  assign last    = s_axis_tvalid & s_axis_tlast;
  assign len_inc = sat_inc16(len_q);
  assign runt_nx = len_inc < 16'(MIN_LEN);
  assign over_nx = over_q | (len_inc > 16'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    usr_d   = usr_q;
    runt_d  = runt_q;
    over_d  = over_q;
    ovl_d   = ovl_q;
    ovl_nx  = ovl_q;
    m_d_d   = dout;
    m_v_d   = 1'b0;
    m_l_d   = 1'b0;
    m_u_d   = 1'b0;
    drop_d  = 1'b0;
    er_d    = 1'b0;
    eo_d    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          push   = 1'b1;
          len_d  = 16'd1;
          over_d = 1'b0;
          if (last) begin
            clr    = 1'b1;
            drop_d = 1'b1;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (beat) begin
          push  = 1'b1;
          len_d = len_inc;
          if (len_q == 16'd5) begin
            if (match) begin
              over_d = over_nx;
              if (last) begin
                usr_d   = s_axis_tuser;
                runt_d  = runt_nx;
                state_d = FLUSH;
              end else begin
                state_d = PASS;
              end
            end else begin
              clr = 1'b1;
              if (last) begin
                drop_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = DROP;
              end
            end
          end else if (last) begin
            clr     = 1'b1;
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PASS: begin
        if (beat) begin
          push   = 1'b1;
          pop    = 1'b1;
          m_v_d  = 1'b1;
          len_d  = len_inc;
          over_d = over_nx;
          if (last) begin
            usr_d   = s_axis_tuser;
            runt_d  = runt_nx;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        pop   = 1'b1;
        m_v_d = 1'b1;
        // A beat here starts a frame we cannot buffer; drop all of it.
        if (beat) begin
          ovl_nx = ~s_axis_tlast;
          drop_d = s_axis_tlast;
        end
        ovl_d = ovl_nx;
        if (cnt == CW'(1)) begin
          m_l_d   = 1'b1;
          m_u_d   = usr_q | runt_q | over_q;
          er_d    = runt_q;
          eo_d    = over_q;
          ovl_d   = 1'b0;
          state_d = ovl_nx ? DROP : IDLE;
        end
      end
      DROP: begin
        if (last) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      usr_q   <= 1'b0;
      runt_q  <= 1'b0;
      over_q  <= 1'b0;
      ovl_q   <= 1'b0;
      m_d_q   <= '0;
      m_v_q   <= 1'b0;
      m_l_q   <= 1'b0;
      m_u_q   <= 1'b0;
      drop_q  <= 1'b0;
      er_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      usr_q   <= usr_d;
      runt_q  <= runt_d;
      over_q  <= over_d;
      ovl_q   <= ovl_d;
      m_d_q   <= m_d_d;
      m_v_q   <= m_v_d;
      m_l_q   <= m_l_d;
      m_u_q   <= m_u_d;
      drop_q  <= drop_d;
      er_q    <= er_d;
      eo_q    <= eo_d;
    end
  end

  assign m_axis_tdata   = m_d_q;
  assign m_axis_tvalid  = m_v_q;
  assign m_axis_tlast   = m_l_q;
  assign m_axis_tuser   = m_u_q;
  assign drop_frame     = drop_q;
  assign error_runt     = er_q;
  assign error_oversize = eo_q;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [31:0] ok_q, err_q, dr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q  <= '0;
      err_q <= '0;
      dr_q  <= '0;
    end else begin
      if (m_v_d & m_l_d & ~m_u_d) ok_q  <= ok_q + 32'd1;
      if (m_v_d & m_l_d &  m_u_d) err_q <= err_q + 32'd1;
      if (drop_d)                 dr_q  <= dr_q + 32'd1;
    end
  end

  assign stat_ok   = ok_q;
  assign stat_err  = err_q;
  assign stat_drop = dr_q;
`else
  assign stat_ok   = '0;
  assign stat_err  = '0;
  assign stat_drop = '0;
`endif

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Randomised bench for eth_rx_addr_filter with a cycle-timed
// expected-output queue derived from the latency rules.
module tb_eth_rx_addr_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [47:0] local_mac;
  logic        promisc, bcast_en, mcast_en;
  logic        drop_frame, error_runt, error_oversize;
  logic [31:0] stat_ok, stat_drop, stat_err;

  always #5 clk = ~clk;

  eth_rx_addr_filter dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .local_mac      (local_mac),
    .promisc        (promisc),
    .bcast_en       (bcast_en),
    .mcast_en       (mcast_en),
    .drop_frame     (drop_frame),
    .error_runt     (error_runt),
    .error_oversize (error_oversize),
    .stat_ok        (stat_ok),
    .stat_drop      (stat_drop),
    .stat_err       (stat_err)
  );

  typedef struct {
    int         c;
    logic [7:0] d;
    bit         l;
    bit         u;
    bit         r;
    bit         o;
  } ev_t;

  ev_t eq[$];
  int  dq[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  outs = 0, drops = 0, runts = 0, overs = 0;
  bit  last_u;
  bit  watch = 0;
  int  seen = -1;
  int  c0 = 0;
  int  m_ok = 0, m_err = 0, m_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic bit match(logic [47:0] d);
    return promisc || d == local_mac
        || (bcast_en && d == 48'hFFFF_FFFF_FFFF)
        || (mcast_en && d[40]);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    bit  ev, ed;
    while (eq.size() > 0 && eq[0].c < cyc) begin
      chk("missed_out", 0, 1);
      void'(eq.pop_front());
    end
    while (dq.size() > 0 && dq[0] < cyc) begin
      chk("missed_drop", 0, 1);
      void'(dq.pop_front());
    end
    ev = eq.size() > 0 && eq[0].c == cyc;
    ed = dq.size() > 0 && dq[0] == cyc;
    chk("tvalid", m_tvalid, ev);
    if (ev) begin
      e = eq.pop_front();
      if (m_tvalid) begin
        chk("tdata", m_tdata, e.d);
        chk("tlast", m_tlast, e.l);
        if (e.l) chk("tuser", m_tuser, e.u);
      end
      chk("err_runt", error_runt, e.l & e.r);
      chk("err_over", error_oversize, e.l & e.o);
    end else begin
      chk("err_idle", {error_runt, error_oversize}, 0);
    end
    chk("drop_frame", drop_frame, ed);
    if (ed) void'(dq.pop_front());
    if (m_tvalid) outs++;
    if (m_tvalid && m_tlast) last_u = m_tuser;
    runts += int'(error_runt);
    overs += int'(error_oversize);
    drops += int'(drop_frame);
    if (watch && m_tvalid) begin
      seen  = cyc;
      watch = 0;
    end
  end

  task automatic chk_stats(string nm);
`ifdef ETH_RX_FILTER_STATS_EN
    chk({nm, "_ok"}, stat_ok, m_ok);
    chk({nm, "_err"}, stat_err, m_err);
    chk({nm, "_drop"}, stat_drop, m_drop);
`else
    chk({nm, "_stats0"}, {stat_ok, stat_err, stat_drop}, 0);
`endif
  endtask

  task automatic send(input int n, input logic [47:0] dst,
                      input bit tu, input bit mii, input int rst_at);
    logic [7:0] b[$];
    bit         pass, r, o, u;
    int         c;
    for (int i = 0; i < n; i++)
      b.push_back(i < 6 ? dst[47-8*i -: 8] : 8'($urandom));
    pass  = n >= 6 && match(dst);
    r     = n < 64;
    o     = n > 1518;
    u     = tu | r | o;
    seen  = -1;
    for (int k = 0; k < n; k++) begin
      if (mii && k > 0) begin
        @(posedge clk); #1;
        s_tvalid = 1'b0;
      end
      if (k == rst_at) begin
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        rst      = 1'b1;
        c        = cyc;
        while (eq.size() > 0 && eq[$].c > c) void'(eq.pop_back());
        while (dq.size() > 0 && dq[$] > c) void'(dq.pop_back());
        m_ok = 0; m_err = 0; m_drop = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 0);
        repeat (10) @(posedge clk);
        #1;
        chk_stats("rst");
        return;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = b[k];
      s_tlast  = (k == n - 1);
      s_tuser  = (k == n - 1) ? tu : 1'($urandom);
      c        = cyc;
      if (k == 0) begin
        c0    = c;
        watch = 1;
      end
      if (pass && k >= 6)
        eq.push_back('{c + 1, b[k-6], 1'b0, 1'b0, 1'b0, 1'b0});
      if (k == n - 1) begin
        if (pass) begin
          for (int j = 0; j < 6; j++)
            eq.push_back('{c + 2 + j, b[n-6+j], j == 5, u, r, o});
          if (u) m_err++;
          else   m_ok++;
        end else begin
          dq.push_back(c + 1);
          m_drop++;
        end
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_stats("frame");
  endtask

  initial begin
    int o, d, rn, ov;
    logic [47:0] bc;
    bc        = 48'hFFFF_FFFF_FFFF;
    rst       = 1'b1;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tuser   = 1'b0;
    local_mac = 48'h02_11_22_33_44_55;
    promisc   = 1'b0;
    bcast_en  = 1'b0;
    mcast_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {m_tvalid, m_tlast, m_tuser, m_tdata}, 0);
    chk("rst_pulses", {drop_frame, error_runt, error_oversize}, 0);
    chk("rst_stats", {stat_ok, stat_err, stat_drop}, 0);

    o = outs;
    send(64, local_mac, 0, 0, -1);
    chk("uc64_bytes", outs - o, 64);
    chk("uc64_tuser", last_u, 0);
    chk("uc64_latency", seen - c0, 7);

    o = outs; d = drops;
    send(64, 48'h02_00_00_00_00_99, 0, 0, -1);
    chk("other_bytes", outs - o, 0);
    chk("other_drops", drops - d, 1);
`ifdef ETH_RX_FILTER_STATS_EN
    chk("other_stat_drop", stat_drop, 1);
`endif

    o = outs; d = drops;
    send(64, bc, 0, 0, -1);
    chk("bc_off_drops", drops - d, 1);
    bcast_en = 1'b1;
    send(64, bc, 0, 0, -1);
    chk("bc_on_bytes", outs - o, 64);
    mcast_en = 1'b1;
    o = outs;
    send(80, 48'h01_00_5E_00_00_01, 0, 0, -1);
    chk("mc_bytes", outs - o, 80);

    o = outs; rn = runts;
    send(40, local_mac, 0, 0, -1);
    chk("runt_bytes", outs - o, 40);
    chk("runt_tuser", last_u, 1);
    chk("runt_pulse", runts - rn, 1);
    o = outs; d = drops;
    send(4, local_mac, 0, 0, -1);
    chk("tiny_drops", drops - d, 1);
    chk("tiny_bytes", outs - o, 0);

    send(64, local_mac, 0, 0, 30);
    o = outs;
    send(100, local_mac, 1, 1, -1);
    chk("mii_bytes", outs - o, 100);
    chk("mii_tuser", last_u, 1);
`ifdef ETH_RX_FILTER_STATS_EN
    chk("mii_stat_err", stat_err, 1);
`endif

    rn = runts; ov = overs;
    send(63, local_mac, 0, 0, -1);
    send(64, local_mac, 0, 1, -1);
    send(6, local_mac, 0, 0, -1);
    send(7, local_mac, 0, 1, -1);
    chk("bound_runts", runts - rn, 3);
    send(1518, local_mac, 0, 0, -1);
    chk("max_over", overs - ov, 0);
    chk("max_tuser", last_u, 0);
    send(1519, local_mac, 0, 0, -1);
    chk("over_pulse", overs - ov, 1);
    chk("over_tuser", last_u, 1);

    for (int i = 0; i < 24; i++) begin
      int          lens[8];
      logic [47:0] dsts[5];
      lens = '{5, 6, 7, 20, 63, 64, 65, 150};
      dsts[0] = local_mac;
      dsts[1] = bc;
      dsts[2] = {8'h01, 40'($urandom)};
      dsts[3] = {8'h02, 8'($urandom), 32'($urandom)};
      dsts[4] = {8'($urandom), 8'($urandom), 32'($urandom)};
      promisc  = ($urandom_range(0, 4) == 0);
      bcast_en = 1'($urandom);
      mcast_en = 1'($urandom);
      send(lens[$urandom_range(0, 7)], dsts[$urandom_range(0, 4)],
           1'($urandom), 1'($urandom), -1);
    end

    chk("queues_empty", eq.size() + dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
